pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register that generalises the fixed ID/EX latch into a reusable stage for any boundary of the 16-bit core (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle with a valid/ready handshake, and it supports flush (bubble insertion), a global write-enable freeze, and a saturating back-pressure counter. An optional two-entry skid buffer registers the upstream ready signal.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_slot.sv | 28 ++
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_reg.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// pipe_pkg: shared ID/EX control layout, bundle widths and ALUOP encodings for the 16-bit core.
package pipe_pkg;

  localparam int XLEN        = 16;
  localparam int CTRL_W_IDEX = 8;
  localparam int DATA_W_IDEX = 128;

  localparam logic [2:0] ALUOP_ADD = 3'd0;
  localparam logic [2:0] ALUOP_SUB = 3'd1;
  localparam logic [2:0] ALUOP_AND = 3'd2;
  localparam logic [2:0] ALUOP_OR  = 3'd3;
  localparam logic [2:0] ALUOP_XOR = 3'd4;
  localparam logic [2:0] ALUOP_SLL = 3'd5;
  localparam logic [2:0] ALUOP_SRL = 3'd6;
  localparam logic [2:0] ALUOP_SLT = 3'd7;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       mem_write;
    logic       mem_read;
    logic       reg_store;
  } idex_ctrl_t;

  function automatic logic [CTRL_W_IDEX-1:0] pack_idex_ctrl(input idex_ctrl_t c);
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// pipe_slot: one pipeline holding slot (valid + payload); clear wins over load and zeroes the payload.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH = CTRL_W_IDEX + DATA_W_IDEX
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_value,
  output logic             valid,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      valid <= 1'b0;
      value <= '0;
    end else if (load) begin
      valid <= 1'b1;
      value <= load_value;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// pipe_stage_reg: valid/ready pipeline stage with flush, freeze and saturating stall counter.
// Optional registered-ready skid slot enabled by defining PIPE_SKID_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_IDEX,
  parameter int DATA_W = DATA_W_IDEX,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [CTRL_W-1:0] InCtrl,
  input  logic [DATA_W-1:0] InData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [CTRL_W-1:0] OutCtrl,
  output logic [DATA_W-1:0] OutData,
  output logic [CNT_W-1:0]  StallCount
);

  localparam int SLOT_W = CTRL_W + DATA_W;

  logic              accept;
  logic              deliver;
  logic              m_load;
  logic              m_clear;
  logic              m_valid;
  logic [SLOT_W-1:0] m_next;
  logic [SLOT_W-1:0] m_value;

  assign accept  = InValid && InReady;
  assign deliver = RegWrite && m_valid && OutReady;

`ifdef PIPE_SKID_EN
  logic              s_load;
  logic              s_clear;
  logic              s_valid;
  logic [SLOT_W-1:0] s_value;

  assign InReady = RegWrite && !s_valid;

  always_comb begin
    m_load  = 1'b0;
    m_clear = Flush;
    m_next  = {InCtrl, InData};
    s_load  = 1'b0;
    s_clear = Flush;
    if (!Flush && RegWrite) begin
      if (!m_valid || deliver) begin
        // S always holds the older beat, so it refills M before the input does.
        if (s_valid) begin
          m_load  = 1'b1;
          m_next  = s_value;
          s_clear = 1'b1;
        end else if (accept) begin
          m_load = 1'b1;
        end else begin
          m_clear = 1'b1;
        end
      end else if (accept) begin
        s_load = 1'b1;
      end
    end
  end

  pipe_slot #(.WIDTH(SLOT_W)) u_skid (
    .clk        (CLK),
    .reset_n    (Reset),
    .load       (s_load),
    .clear      (s_clear),
    .load_value ({InCtrl, InData}),
    .valid      (s_valid),
    .value      (s_value)
  );
`else
  assign InReady = RegWrite && (!m_valid || OutReady);

  always_comb begin
    m_load  = !Flush && accept;
    m_clear = Flush || (deliver && !accept);
    m_next  = {InCtrl, InData};
  end
`endif

  pipe_slot #(.WIDTH(SLOT_W)) u_main (
    .clk        (CLK),
    .reset_n    (Reset),
    .load       (m_load),
    .clear      (m_clear),
    .load_value (m_next),
    .valid      (m_valid),
    .value      (m_value)
  );

  assign OutValid           = m_valid;
  assign {OutCtrl, OutData} = m_valid ? m_value : '0;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      StallCount <= '0;
    end else if (RegWrite && m_valid && !OutReady && !Flush && !(&StallCount)) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// tb_pipe_stage_reg: directed and random stimulus checked against a queue-based stage model.
module tb_pipe_stage_reg;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } beat_t;

  logic              CLK = 1'b0;
  logic              Reset;
  logic              RegWrite;
  logic              Flush;
  logic              InValid;
  logic              InReady;
  logic [CTRL_W-1:0] InCtrl;
  logic [DATA_W-1:0] InData;
  logic              OutValid;
  logic              OutReady;
  logic [CTRL_W-1:0] OutCtrl;
  logic [DATA_W-1:0] OutData;
  logic [CNT_W-1:0]  StallCount;

  beat_t q[$];
  int    cnt;
  int    n_cmp = 0;
  int    n_err = 0;
  logic  last_acc;
  int    idx;

  localparam logic [DATA_W-1:0] PASS_DATA = {16'hA5A5, 16'h1234, 16'h5678, 16'h9ABC,
                                             16'hFEDC, 16'h2468, 16'hBEEF, 16'hC0DE};

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .RegWrite   (RegWrite),
    .Flush      (Flush),
    .InValid    (InValid),
    .InReady    (InReady),
    .InCtrl     (InCtrl),
    .InData     (InData),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutCtrl    (OutCtrl),
    .OutData    (OutData),
    .StallCount (StallCount)
  );

  always #5 CLK = ~CLK;

  // Stage capacity is CAP beats; without a skid the stage can only take a beat if it frees one.
  function automatic logic model_ready();
    if (CAP == 2) return RegWrite && (q.size() < 2);
    return RegWrite && (q.size() == 0 || OutReady);
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    beat_t e;
    e = '0;
    if (q.size() != 0) e = q[0];
    chk("out_valid", OutValid, q.size() != 0);
    chk("out_ctrl", OutCtrl, e.c);
    chk("out_data", OutData, e.d);
    chk("stall_count", StallCount, cnt);
  endtask

  task automatic cycle();
    logic  rdy, rst, fl, rw, ordy;
    beat_t b;
    #1;
    rdy = model_ready();
    chk("in_ready", InReady, rdy);
    last_acc = InValid && rdy;
    b    = '{c: InCtrl, d: InData};
    rst  = Reset;
    fl   = Flush;
    rw   = RegWrite;
    ordy = OutReady;
    @(posedge CLK);
    if (!rst) begin
      q.delete();
      cnt = 0;
    end else if (fl) begin
      q.delete();
    end else if (rw) begin
      if (q.size() != 0 && !ordy && cnt < CNT_MAX) cnt++;
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (last_acc) q.push_back(b);
    end
    #1;
    check_out();
  endtask

  initial begin
    // Reset with junk presented on the input.
    Reset = 1'b0; RegWrite = 1'b1; Flush = 1'b0; OutReady = 1'b0;
    InValid = 1'b1; InCtrl = 8'hA5; InData = {8{16'hA5A5}};
    repeat (2) @(posedge CLK);
    #1;
    q.delete();
    cnt = 0;
    check_out();
    chk("reset_in_ready", InReady, 1'b1);
    chk("reset_out_data", OutData, '0);

    // Pass-through.
    Reset = 1'b1; OutReady = 1'b1; InValid = 1'b1; InCtrl = 8'hFF; InData = PASS_DATA;
    cycle();
    chk("pass_ctrl", OutCtrl, 8'hFF);
    chk("pass_data", OutData, PASS_DATA);
    InValid = 1'b0;
    cycle();

    // Back-pressure: beats 1..4, OutReady low for 3 cycles.
    Reset = 1'b0; cycle(); Reset = 1'b1;
    idx = 0;
    for (int t = 0; t < 12; t++) begin
      OutReady = !(t >= 2 && t < 5);
      InValid  = (idx < 4);
      InCtrl   = 8'(idx + 1);
      InData   = 128'(idx + 1);
      cycle();
      if (last_acc) idx++;
      if (t == 4) chk("bp_stall3", StallCount, 3);
    end
    chk("bp_all_accepted", idx, 4);
    InValid = 1'b0;

    // Flush colliding with accept and deliver (skid slot loaded beforehand).
    OutReady = 1'b0; InValid = 1'b1; InCtrl = 8'h11; InData = 128'h11;
    cycle();
    InCtrl = 8'h22; InData = 128'h22;
    cycle();
    OutReady = 1'b1; Flush = 1'b1; InCtrl = 8'h33; InData = 128'h33;
    cycle();
    chk("flush_valid", OutValid, 1'b0);
    chk("flush_data", OutData, '0);
    Flush = 1'b0; InValid = 1'b0;
    cycle();
    chk("flush_skid_gone", OutValid, 1'b0);

    // Freeze with a held beat and pending input.
    InValid = 1'b1; InCtrl = 8'h5A; InData = {$urandom(), $urandom(), $urandom(), $urandom()};
    cycle();
    OutReady = 1'b0; RegWrite = 1'b0; InCtrl = 8'h77;
    repeat (5) begin
      cycle();
      chk("freeze_ctrl", OutCtrl, 8'h5A);
      chk("freeze_in_ready", InReady, 1'b0);
    end
    RegWrite = 1'b1; OutReady = 1'b1; InValid = 1'b0;
    cycle();
    cycle();

    // Saturation of the 4-bit counter.
    Reset = 1'b0; cycle(); Reset = 1'b1;
    InValid = 1'b1; OutReady = 1'b0; InCtrl = 8'h0F; InData = 128'hF00D;
    cycle();
    InValid = 1'b0;
    repeat (20) cycle();
    chk("sat_count", StallCount, 4'hF);

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      Reset    = ($urandom_range(0, 99) != 0);
      Flush    = ($urandom_range(0, 19) == 0);
      RegWrite = ($urandom_range(0, 9) != 0);
      InValid  = ($urandom_range(0, 1) != 0);
      OutReady = ($urandom_range(0, 2) != 0);
      InCtrl   = 8'($urandom());
      InData   = {$urandom(), $urandom(), $urandom(), $urandom()};
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
